imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 85 ++++++++
 tb/tb_imem_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: two-port (fetch/debug) arbiter for a combinational-read instruction memory, optional debug anti-starvation via IMEM_ARB_STARVE_EN
module imem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_valid,
  input  logic [AW-1:0] f_addr,
  output logic          f_ready,
  output logic          f_rsp_valid,
  output logic [DW-1:0] f_rsp_data,
  input  logic          d_valid,
  input  logic [AW-1:0] d_addr,
  output logic          d_ready,
  output logic          d_rsp_valid,
  output logic [DW-1:0] d_rsp_data,
  output logic          rsp_err,
  output logic [AW-1:0] imem_a,
  input  logic [DW-1:0] imem_rd
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RSP_F = 2'd1;
  localparam logic [1:0] RSP_D = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] f_data_q, f_data_d, d_data_q, d_data_d;
  logic          err_q, err_d;
  logic          d_force, f_acc, d_acc, mis;

`ifdef IMEM_ARB_STARVE_EN
  logic [2:0] cnt_q, cnt_d;
  // count consecutive debug losses to fetch, saturating at the forcing threshold
  always_comb
    cnt_d = (!d_valid || d_acc) ? 3'd0 :
            (f_acc && cnt_q != 3'(STARVE_MAX)) ? cnt_q + 3'd1 : cnt_q;
  // starvation counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 3'd0;
    else        cnt_q <= cnt_d;
  assign d_force = d_valid && cnt_q == 3'(STARVE_MAX);
`else
  // strict fetch priority: debug is never forced through
  assign d_force = 1'b0 & (STARVE_MAX != 0);
`endif

  assign f_ready     = rst_n & f_valid & ~d_force;
  assign d_ready     = rst_n & d_valid & (~f_valid | d_force);
  assign f_acc       = f_valid & f_ready;
  assign d_acc       = d_valid & d_ready;
  assign imem_a      = a_d;
  assign f_rsp_valid = state_q == RSP_F;
  assign d_rsp_valid = state_q == RSP_D;
  assign f_rsp_data  = f_data_q;
  assign d_rsp_data  = d_data_q;
  assign rsp_err     = err_q;

  // route the accepted request to memory and capture its word into the owner's response register
  always_comb begin
    mis      = f_acc ? f_addr[1:0] != 2'd0 : d_addr[1:0] != 2'd0;
    state_d  = f_acc ? RSP_F : d_acc ? RSP_D : IDLE;
    a_d      = f_acc ? f_addr : d_acc ? d_addr : a_q;
    err_d    = (f_acc | d_acc) & mis;
    f_data_d = f_acc ? (mis ? '0 : imem_rd) : f_data_q;
    d_data_d = d_acc ? (mis ? '0 : imem_rd) : d_data_q;
  end

  // response state and held address/data registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      f_data_q <= '0;
      d_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      f_data_q <= f_data_d;
      d_data_q <= d_data_d;
      err_q    <= err_d;
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed self-checking bench for imem_arbiter
module tb_imem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        f_valid = 1'b0, d_valid = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0;
  logic        f_ready, d_ready, f_rsp_valid, d_rsp_valid, rsp_err;
  logic [31:0] f_rsp_data, d_rsp_data, imem_a, imem_rd;
  int          vecs = 0, errs = 0;

  always #5 clk = ~clk;

  // memory contents: word at address A reads as 0x1000_0000 | A
  assign imem_rd = 32'h1000_0000 | imem_a;

  imem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_ready(d_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .rsp_err(rsp_err), .imem_a(imem_a), .imem_rd(imem_rd)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    f_valid = 1'b1; d_valid = 1'b1;
    #3;
    vecs++; if (f_ready !== 1'b0) begin errs++; $display("FAIL rst_f_ready: got %b exp 0", f_ready); end
    vecs++; if (d_ready !== 1'b0) begin errs++; $display("FAIL rst_d_ready: got %b exp 0", d_ready); end
    vecs++; if (imem_a !== 32'h0) begin errs++; $display("FAIL rst_imem_a: got %h exp 0", imem_a); end
    vecs++; if ({f_rsp_valid, d_rsp_valid, rsp_err} !== 3'b000) begin errs++; $display("FAIL rst_valids: got %b exp 000", {f_rsp_valid, d_rsp_valid, rsp_err}); end
    vecs++; if ({f_rsp_data, d_rsp_data} !== 64'h0) begin errs++; $display("FAIL rst_data: got %h exp 0", {f_rsp_data, d_rsp_data}); end
    f_valid = 1'b0; d_valid = 1'b0;
    step; step;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_fetch_seq;
    for (int i = 0; i < 6; i++) begin
      f_valid = 1'b1; f_addr = 32'(4 * i);
      @(negedge clk);
      vecs++; if ({f_ready, d_ready} !== 2'b10) begin errs++; $display("FAIL seq_ready[%0d]: got %b exp 10", i, {f_ready, d_ready}); end
      vecs++; if (imem_a !== 32'(4 * i)) begin errs++; $display("FAIL seq_imem_a[%0d]: got %h exp %h", i, imem_a, 4 * i); end
      step;
      vecs++; if ({f_rsp_valid, d_rsp_valid, rsp_err} !== 3'b100) begin errs++; $display("FAIL seq_valid[%0d]: got %b exp 100", i, {f_rsp_valid, d_rsp_valid, rsp_err}); end
      vecs++; if (f_rsp_data !== (32'h1000_0000 | 32'(4 * i))) begin errs++; $display("FAIL seq_data[%0d]: got %h exp %h", i, f_rsp_data, 32'h1000_0000 | 32'(4 * i)); end
    end
    f_valid = 1'b0;
    step;
    vecs++; if ({f_rsp_valid, d_rsp_valid} !== 2'b00) begin errs++; $display("FAIL seq_idle_valid: got %b exp 00", {f_rsp_valid, d_rsp_valid}); end
    vecs++; if (imem_a !== 32'd20) begin errs++; $display("FAIL seq_idle_addr: got %h exp 14", imem_a); end
    vecs++; if (f_rsp_data !== 32'h1000_0014) begin errs++; $display("FAIL seq_hold_data: got %h exp 10000014", f_rsp_data); end
  endtask

  task automatic test_starve;
    logic [5:0] exp_d;
`ifdef IMEM_ARB_STARVE_EN
    exp_d = 6'b010000;
`else
    exp_d = 6'b000000;
`endif
    f_valid = 1'b1; f_addr = 32'h40; d_valid = 1'b1; d_addr = 32'h80;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vecs++; if ({f_ready, d_ready} !== {~exp_d[i], exp_d[i]}) begin errs++; $display("FAIL starve_grant[%0d]: got %b exp %b", i, {f_ready, d_ready}, {~exp_d[i], exp_d[i]}); end
      step;
      vecs++; if ({f_rsp_valid, d_rsp_valid} !== {~exp_d[i], exp_d[i]}) begin errs++; $display("FAIL starve_rsp[%0d]: got %b exp %b", i, {f_rsp_valid, d_rsp_valid}, {~exp_d[i], exp_d[i]}); end
    end
    f_valid = 1'b0; d_valid = 1'b0;
    step;
`ifdef IMEM_ARB_STARVE_EN
    vecs++; if (d_rsp_data !== 32'h1000_0080) begin errs++; $display("FAIL starve_d_data: got %h exp 10000080", d_rsp_data); end
`endif
  endtask

  task automatic test_misaligned;
    d_valid = 1'b1; d_addr = 32'h6;
    @(negedge clk);
    vecs++; if ({f_ready, d_ready} !== 2'b01) begin errs++; $display("FAIL mis_ready: got %b exp 01", {f_ready, d_ready}); end
    step;
    d_valid = 1'b0;
    vecs++; if ({f_rsp_valid, d_rsp_valid, rsp_err} !== 3'b011) begin errs++; $display("FAIL mis_valid: got %b exp 011", {f_rsp_valid, d_rsp_valid, rsp_err}); end
    vecs++; if (d_rsp_data !== 32'h0) begin errs++; $display("FAIL mis_data: got %h exp 0", d_rsp_data); end
    step;
    vecs++; if ({d_rsp_valid, rsp_err} !== 2'b00) begin errs++; $display("FAIL mis_clear: got %b exp 00", {d_rsp_valid, rsp_err}); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [4];
    addrs = '{32'h10, 32'h24, 32'h30, 32'h44};
    for (int i = 0; i < 4; i++) begin
      f_valid = (i % 2 == 0); d_valid = (i % 2 == 1);
      f_addr = addrs[i]; d_addr = addrs[i];
      step;
      vecs++; if ({f_rsp_valid, d_rsp_valid} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errs++; $display("FAIL alt_route[%0d]: got %b", i, {f_rsp_valid, d_rsp_valid}); end
      vecs++; if (((i % 2 == 0) ? f_rsp_data : d_rsp_data) !== (32'h1000_0000 | addrs[i])) begin errs++; $display("FAIL alt_data[%0d]: got %h exp %h", i, (i % 2 == 0) ? f_rsp_data : d_rsp_data, 32'h1000_0000 | addrs[i]); end
      if (i == 1) begin
        vecs++; if (f_rsp_data !== 32'h1000_0010) begin errs++; $display("FAIL alt_hold: got %h exp 10000010", f_rsp_data); end
      end
    end
    f_valid = 1'b0; d_valid = 1'b0;
    step;
    vecs++; if ({f_rsp_valid, d_rsp_valid} !== 2'b00) begin errs++; $display("FAIL alt_end: got %b exp 00", {f_rsp_valid, d_rsp_valid}); end
  endtask

  task automatic test_drop;
    f_valid = 1'b1; f_addr = 32'h50;
    @(negedge clk);
    f_valid = 1'b0;
    step;
    vecs++; if (f_rsp_valid !== 1'b0) begin errs++; $display("FAIL drop_valid: got %b exp 0", f_rsp_valid); end
    vecs++; if (f_rsp_data !== 32'h1000_0030) begin errs++; $display("FAIL drop_data: got %h exp 10000030", f_rsp_data); end
  endtask

  task automatic test_reset_mid;
    f_valid = 1'b1; f_addr = 32'h8;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++; if ({f_ready, imem_a} !== 33'h0) begin errs++; $display("FAIL rmid_now: got %h exp 0", {f_ready, imem_a}); end
    vecs++; if (f_rsp_data !== 32'h0) begin errs++; $display("FAIL rmid_data: got %h exp 0", f_rsp_data); end
    step;
    vecs++; if (f_rsp_valid !== 1'b0) begin errs++; $display("FAIL rmid_valid: got %b exp 0", f_rsp_valid); end
    f_valid = 1'b0;
    rst_n = 1'b1;
    step;
    vecs++; if ({f_rsp_valid, d_rsp_valid, rsp_err} !== 3'b000) begin errs++; $display("FAIL rmid_after: got %b exp 000", {f_rsp_valid, d_rsp_valid, rsp_err}); end
  endtask

  initial begin
    test_reset;
    test_fetch_seq;
    test_starve;
    test_misaligned;
    test_back_to_back;
    test_drop;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
